// File: rtl/ring_pkg.sv
// Shared types and constants for the ring/Johnson counter: mode and direction
// encodings plus the pattern used both at reset and for illegal-state recovery.
package ring_pkg;

  typedef enum logic {
    RING    = 1'b0,
    JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // 0..01 is a legal state in both modes, so it doubles as the recovery target.
  function automatic logic [31:0] reset_pattern();
    return 32'h0000_0001;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check and sequence-position decode of a counter state
// for the selected mode (RING one-hot or JOHNSON twisted-ring).
module ring_state_check
  import ring_pkg::*;
#(
  parameter int WIDTH_REG = 8,
  parameter int IDX_W     = $clog2(2*WIDTH_REG)
) (
  input  logic [WIDTH_REG-1:0] state,
  input  logic                 mode,
  output logic                 legal,
  output logic [IDX_W-1:0]     idx
);

  // True for 0..01..1 patterns (including all-zero and all-one).
  function automatic logic is_therm(input logic [WIDTH_REG-1:0] v);
    logic [WIDTH_REG-1:0] inc;
    inc = v + {{(WIDTH_REG-1){1'b0}}, 1'b1};
    return ((v & inc) == {WIDTH_REG{1'b0}});
  endfunction

  logic [IDX_W-1:0] ones_cnt_s;
  logic [IDX_W-1:0] zeros_cnt_s;
  logic [IDX_W-1:0] top_pos_s;

  always_comb begin
    ones_cnt_s  = '0;
    zeros_cnt_s = '0;
    top_pos_s   = '0;
    for (int i = 0; i < WIDTH_REG; i++) begin
      if (state[i]) begin
        ones_cnt_s = ones_cnt_s + IDX_W'(1);
        top_pos_s  = IDX_W'(i);
      end else begin
        zeros_cnt_s = zeros_cnt_s + IDX_W'(1);
      end
    end
  end

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    case (mode_e'(mode))
      RING: begin
        if (ones_cnt_s == IDX_W'(1)) begin
          legal = 1'b1;
          idx   = top_pos_s;
        end else begin
          legal = 1'b0;
        end
      end
      JOHNSON: begin
        // Second half of the sequence is ones above k low zeros, i.e. ~state is a thermometer.
        if (is_therm(state)) begin
          legal = 1'b1;
          idx   = ones_cnt_s;
        end else if (is_therm(~state)) begin
          legal = 1'b1;
          idx   = IDX_W'(WIDTH_REG) + zeros_cnt_s;
        end else begin
          legal = 1'b0;
        end
      end
      default: begin
        legal = 1'b0;
        idx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Up/down ring or Johnson counter with synchronous load, illegal-state
// self-correction, and registered wrap / error pulses.
module ring_johnson_counter
  import ring_pkg::*;
#(
  parameter int WIDTH_REG = 8,
  parameter int IDX_W     = $clog2(2*WIDTH_REG)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 dir,
  input  logic                 load,
  input  logic [WIDTH_REG-1:0] load_val,
  output logic [WIDTH_REG-1:0] out_ring,
  output logic [IDX_W-1:0]     idx,
  output logic                 wrap,
  output logic                 err
);

  localparam logic [WIDTH_REG-1:0] RST_PAT   = WIDTH_REG'(reset_pattern());
  localparam logic [IDX_W-1:0]     RING_LAST = IDX_W'(WIDTH_REG - 1);
  localparam logic [IDX_W-1:0]     JOHN_LAST = IDX_W'(2*WIDTH_REG - 1);

  logic [WIDTH_REG-1:0] state_q, state_d, step_s;
  logic                 wrap_q, wrap_d, err_q, err_d;
  logic                 cur_legal_s, ld_legal_s;
  logic [IDX_W-1:0]     cur_idx_s, last_idx_s;
  logic [IDX_W-1:0]     ld_idx_unused_s;

  ring_state_check #(.WIDTH_REG(WIDTH_REG), .IDX_W(IDX_W)) u_cur_check (
    .state (state_q),
    .mode  (mode),
    .legal (cur_legal_s),
    .idx   (cur_idx_s)
  );

  ring_state_check #(.WIDTH_REG(WIDTH_REG), .IDX_W(IDX_W)) u_load_check (
    .state (load_val),
    .mode  (mode),
    .legal (ld_legal_s),
    .idx   (ld_idx_unused_s)
  );

  assign last_idx_s = (mode_e'(mode) == JOHNSON) ? JOHN_LAST : RING_LAST;

  always_comb begin
    step_s = state_q;
    case ({mode, dir})
      2'b00:   step_s = {state_q[WIDTH_REG-2:0], state_q[WIDTH_REG-1]};
      2'b01:   step_s = {state_q[0], state_q[WIDTH_REG-1:1]};
      2'b10:   step_s = {state_q[WIDTH_REG-2:0], ~state_q[WIDTH_REG-1]};
      2'b11:   step_s = {~state_q[0], state_q[WIDTH_REG-1:1]};
      default: step_s = state_q;
    endcase
  end

  // Priority: load, then recovery from an illegal state, then stepping, then hold.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (ld_legal_s) begin
        state_d = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (!cur_legal_s) begin
      state_d = RST_PAT;
      err_d   = 1'b1;
    end else if (en) begin
      state_d = step_s;
      if (dir_e'(dir) == UP) begin
        wrap_d = (cur_idx_s == last_idx_s);
      end else begin
        wrap_d = (cur_idx_s == '0);
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RST_PAT;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_ring = state_q;
  assign idx      = cur_idx_s;
  assign wrap     = wrap_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Scoreboard bench for ring_johnson_counter (WIDTH_REG=4): directed sequences
// plus randomized traffic against a sequence-table reference model.
module tb_ring_johnson_counter;

  localparam int W = 4;

  logic         clk, n_rst, en, mode, dir, load;
  logic [W-1:0] load_val, out_ring;
  logic [2:0]   idx;
  logic         wrap, err;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] ix;
    logic       wr;
    logic       er;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_st;
  logic       md;

  ring_johnson_counter #(.WIDTH_REG(W)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .out_ring (out_ring),
    .idx      (idx),
    .wrap     (wrap),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k-th element of the mode's sequence, built from the textual rules.
  function automatic logic [3:0] seq(input logic m, input int k);
    int v;
    if (!m) v = 1 << k;
    else if (k <= W) v = (1 << k) - 1;
    else v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    return 4'(v);
  endfunction

  function automatic int find(input logic [3:0] s, input logic m);
    int len;
    int r;
    len = m ? 2*W : W;
    r = -1;
    for (int k = 0; k < len; k++) if (seq(m, k) == s) r = k;
    return r;
  endfunction

  task automatic apply(input logic e, input logic m, input logic d, input logic ld, input logic [3:0] lv);
    @(negedge clk);
    en = e; mode = m; dir = d; load = ld; load_val = lv;
  endtask

  // Randomized / model-checked cycle.
  task automatic drive(input logic e, input logic m, input logic d, input logic ld, input logic [3:0] lv);
    int cur, len, nk, ni;
    logic wr, er;
    apply(e, m, d, ld, lv);
    len = m ? 2*W : W;
    cur = find(m_st, m);
    wr = 1'b0; er = 1'b0;
    if (ld) begin
      if (find(lv, m) >= 0) m_st = lv; else er = 1'b1;
    end else if (cur < 0) begin
      m_st = 4'b0001; er = 1'b1;
    end else if (e) begin
      if (!d) begin nk = (cur + 1) % len; wr = (cur == len - 1); end
      else    begin nk = (cur + len - 1) % len; wr = (cur == 0); end
      m_st = seq(m, nk);
    end
    ni = find(m_st, m);
    if (ni < 0) ni = 0;
    exp_q.push_back({m_st, 3'(ni), wr, er});
  endtask

  // Directed cycle with a hand-written expectation.
  task automatic dexp(input logic e, input logic m, input logic d, input logic ld, input logic [3:0] lv,
                      input logic [3:0] st, input logic [2:0] ix, input logic wr, input logic er);
    apply(e, m, d, ld, lv);
    m_st = st;
    exp_q.push_back({st, ix, wr, er});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: one registered result per clock while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({out_ring, idx, wrap, err} !== e) begin
          errors++;
          $display("FAIL out_chk: got out=%b idx=%0d wrap=%b err=%b want out=%b idx=%0d wrap=%b err=%b",
                   out_ring, idx, wrap, err, e.st, e.ix, e.wr, e.er);
        end
        checks++;
        if (wrap === 1'b1 && err === 1'b1) begin
          errors++;
          $display("FAIL excl: got wrap=1 err=1 want not both");
        end
      end
    end
  end

  initial begin
    n_rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    md = 1'b0; m_st = 4'b0001;
    #1 n_rst = 1'b0;
    #2;
    chk("rst_out", 32'(out_ring), 32'h1);
    chk("rst_idx", 32'(idx), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // RING UP
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 3'd1, 1'b0, 1'b0);
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0100, 3'd2, 1'b0, 1'b0);
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b1000, 3'd3, 1'b0, 1'b0);
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0001, 3'd0, 1'b1, 1'b0);
    // JOHNSON UP from 0001
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0011, 3'd2, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0111, 3'd3, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b1111, 3'd4, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b1110, 3'd5, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b1100, 3'd6, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b1000, 3'd7, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0000, 3'd0, 1'b1, 1'b0);
    dexp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0001, 3'd1, 1'b0, 1'b0);
    // RING DOWN wrap, then hold
    dexp(1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 4'b1000, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) dexp(1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 4'b1000, 3'd3, 1'b0, 1'b0);
    // Loads: legal, illegal, legal
    dexp(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0, 1'b0);
    dexp(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0100, 3'd2, 1'b0, 1'b1);
    dexp(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010, 3'd1, 1'b0, 1'b0);
    // JOHNSON 0111 then switch to RING: correction regardless of en
    dexp(1'b0, 1'b1, 1'b0, 1'b1, 4'b0111, 4'b0111, 3'd3, 1'b0, 1'b0);
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0001, 3'd0, 1'b0, 1'b1);
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 3'd1, 1'b0, 1'b0);
    // JOHNSON DOWN from 0000 wraps to 1000
    dexp(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    dexp(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 4'b1000, 3'd7, 1'b1, 1'b0);

    // Async reset mid-count while an err pulse is showing
    dexp(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000, 3'd3, 1'b0, 1'b0);
    dexp(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b1000, 3'd3, 1'b0, 1'b1);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("arst_out", 32'(out_ring), 32'h1);
    chk("arst_idx", 32'(idx), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    @(negedge clk);
    load = 1'b0;
    n_rst = 1'b1;
    m_st = 4'b0001;
    dexp(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 3'd1, 1'b0, 1'b0);

    // Randomized traffic against the model
    md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) md = ~md;
      drive($urandom_range(0, 3) != 0, md, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end
    drive(1'b0, md, 1'b0, 1'b0, 4'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter.md
RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 Parameter WIDTH_REG, default 8, shall set the state register width; legal range 2..32.
REQ-002 Parameter IDX_W, default $clog2(2*WIDTH_REG), shall set the width of idx; it is derived and is not overridden.
REQ-003 clk  input  1  single clock; all state shall update on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous assert and active-low.
REQ-005 en  input  1  step enable.
REQ-006 mode  input  1  counter mode: 0 = RING (one-hot rotate), 1 = JOHNSON (twisted ring).
REQ-007 dir  input  1  step direction: 0 = UP (toward the MSB), 1 = DOWN.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH_REG  value to load.
REQ-010 out_ring  output  WIDTH_REG  counter state, driven directly from a register.
REQ-011 idx  output  IDX_W  binary position of out_ring within the current mode's sequence; combinational from out_ring and mode.
REQ-012 wrap  output  1  registered one-cycle pulse on sequence wrap-around.
REQ-013 err  output  1  registered one-cycle pulse on an illegal-state correction or a rejected load.

Function
REQ-014 RING step: UP shall produce {s[W-2:0], s[W-1]}; DOWN shall produce {s[0], s[W-1:1]}.
REQ-015 JOHNSON step: UP shall produce {s[W-2:0], ~s[W-1]}; DOWN shall produce {~s[0], s[W-1:1]}.
REQ-016 RING legal states: exactly one bit set.
REQ-017 RING idx: the position of the set bit, giving 0..W-1.
REQ-018 JOHNSON legal states: either k ones packed at the LSB end (0..01..1, k = 0..W) or k zeros packed at the LSB end below ones (1..10..0, k = 1..W-1).
REQ-019 JOHNSON idx: k for the first form; W+k for the second form; range 0..2W-1.
REQ-020 For an illegal state, idx shall be 0.
REQ-021 Next-state priority, highest first: reset > load > illegal correction > en step > hold.
REQ-022 load=1 with load_val legal for the current mode shall make out_ring = load_val next cycle; wrap = 0; err = 0.
REQ-023 load=1 with load_val illegal shall leave out_ring unchanged and pulse err for one cycle.
REQ-024 When out_ring is illegal for the current mode (e.g. after a mode change) and load=0, the next state shall be 0..01 and err shall pulse, regardless of en.
REQ-025 en=1, no load, legal state: out_ring shall advance one step per cycle; latency 1 clock.
REQ-026 wrap shall assert in the cycle out_ring first shows the wrapped state: UP step taken from the terminal idx (W-1 RING, 2W-1 JOHNSON), or DOWN step taken from idx 0.
REQ-027 en=0, no load, legal state: out_ring shall hold; wrap = 0; err = 0.
REQ-028 mode and dir shall be sampled every cycle; a change takes effect on the next edge with no pipeline delay.
REQ-029 err and wrap shall never both be 1 in the same cycle.

Reset
REQ-030 While n_rst=0: out_ring = {0..0,1}, wrap = 0, err = 0, asynchronously and independent of clk.
REQ-031 Reset value 0..01 shall be legal in both modes (RING idx 0, JOHNSON idx 1).
REQ-032 Reset asserted mid-count shall clear immediately; after deassertion the first enabled edge shall step from 0..01.

Structure
REQ-033 A shared package ring_pkg shall hold the mode_e enum (RING, JOHNSON) and dir_e enum (UP, DOWN).
REQ-034 ring_pkg shall hold the reset/correction pattern function.
REQ-035 Sub-module ring_state_check (purely combinational; inputs state and mode; outputs legal and idx) shall be instantiated once for out_ring and once for load_val.

Verification (WIDTH_REG=4)
REQ-036 Reset, RING, UP, en=1 for 5 clocks -> out_ring 0001,0010,0100,1000,0001; wrap on the 5th; idx 0,1,2,3,0.
REQ-037 JOHNSON, UP from 0001 -> 0011,0111,1111,1110,1100,1000,0000,0001; wrap only on 0000; idx follows 1..7,0,1.
REQ-038 RING, DOWN from 0001 -> 1000 with wrap=1; then en=0 for 3 clocks -> 1000 held, wrap=0.
REQ-039 RING at 0100, load=1 with load_val=0110 -> state 0100 kept, err pulse; then load_val=0010 -> 0010, err=0.
REQ-040 JOHNSON at 0111, switch mode to RING -> next 0001 with err=1; the following step -> 0010.
REQ-041 n_rst pulsed low between edges while at 1000 -> out_ring 0001 immediately; wrap=0, err=0.
